// File: rtl/parking_control.sv
// rtl/parking_control.sv - gate/hour-key/rush-hour command pulse generator for the parking-lot datapath
// Optional build macro PARKING_CONTROL_FULL_GUARD_EN: suppress enter when full and exit when empty.
module parking_control #(
  parameter int CAPACITY  = 3,
  parameter int DAY_HOURS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sensor_a,
  input  logic       sensor_b,
  input  logic       hour_key,
  input  logic [3:0] count,
  input  logic [3:0] hour,
  output logic       enter,
  output logic       exit,
  output logic       hour_inc,
  output logic       start_rush,
  output logic       end_rush,
  output logic       no_rush,
  output logic       day_done
);

  localparam logic [3:0] CAP = 4'(CAPACITY);
  localparam logic [3:0] DAY = 4'(DAY_HOURS);

  typedef enum logic [2:0] {
    G_IDLE, G_IN1, G_IN2, G_IN3, G_OUT1, G_OUT2, G_OUT3
  } gate_e;

  typedef enum logic [1:0] {
    R_WAIT, R_RUSH, R_DONE, R_NONE
  } rush_e;

  // Bit order in both sync stages: {sensor_a, sensor_b, hour_key}.
  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;
  logic       k_prev_q, k_prev_d;
  gate_e      gate_q, gate_d;
  rush_e      rush_q, rush_d;
  logic       enter_q, enter_d;
  logic       exit_q, exit_d;
  logic       hour_inc_q, hour_inc_d;
  logic       start_rush_q, start_rush_d;
  logic       end_rush_q, end_rush_d;
  logic       no_rush_q, no_rush_d;
  logic       day_done_q, day_done_d;

  logic [1:0] ab;
  logic       k;
  logic       enter_ok;
  logic       exit_ok;
  logic       day_over;

  assign ab       = sync_q[2:1];
  assign k        = sync_q[0];
  assign day_over = (hour >= DAY);

`ifdef PARKING_CONTROL_FULL_GUARD_EN
  assign enter_ok = (count != CAP);
  assign exit_ok  = (count != 4'd0);
`else
  assign enter_ok = 1'b1;
  assign exit_ok  = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q       <= 3'b000;
      sync_q       <= 3'b000;
      k_prev_q     <= 1'b0;
      gate_q       <= G_IDLE;
      rush_q       <= R_WAIT;
      enter_q      <= 1'b0;
      exit_q       <= 1'b0;
      hour_inc_q   <= 1'b0;
      start_rush_q <= 1'b0;
      end_rush_q   <= 1'b0;
      no_rush_q    <= 1'b0;
      day_done_q   <= 1'b0;
    end else begin
      meta_q       <= meta_d;
      sync_q       <= sync_d;
      k_prev_q     <= k_prev_d;
      gate_q       <= gate_d;
      rush_q       <= rush_d;
      enter_q      <= enter_d;
      exit_q       <= exit_d;
      hour_inc_q   <= hour_inc_d;
      start_rush_q <= start_rush_d;
      end_rush_q   <= end_rush_d;
      no_rush_q    <= no_rush_d;
      day_done_q   <= day_done_d;
    end
  end

  always_comb begin
    meta_d     = {sensor_a, sensor_b, hour_key};
    sync_d     = meta_q;
    k_prev_d   = k;
    hour_inc_d = k && !k_prev_q && !day_over;
    day_done_d = day_over;
  end

  // Gate FSM: a car must walk the full a -> ab -> b (or reverse) pattern to count.
  always_comb begin
    gate_d  = gate_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    case (gate_q)
      G_IDLE: begin
        if (ab == 2'b10)      gate_d = G_IN1;
        else if (ab == 2'b01) gate_d = G_OUT1;
      end
      G_IN1: begin
        if (ab == 2'b11)      gate_d = G_IN2;
        else if (ab == 2'b00) gate_d = G_IDLE;
      end
      G_IN2: begin
        if (ab == 2'b01)      gate_d = G_IN3;
        else if (ab == 2'b10) gate_d = G_IN1;
      end
      G_IN3: begin
        if (ab == 2'b00) begin
          gate_d  = G_IDLE;
          enter_d = enter_ok;
        end else if (ab == 2'b11) begin
          gate_d = G_IN2;
        end
      end
      G_OUT1: begin
        if (ab == 2'b11)      gate_d = G_OUT2;
        else if (ab == 2'b00) gate_d = G_IDLE;
      end
      G_OUT2: begin
        if (ab == 2'b10)      gate_d = G_OUT3;
        else if (ab == 2'b01) gate_d = G_OUT1;
      end
      G_OUT3: begin
        if (ab == 2'b00) begin
          gate_d = G_IDLE;
          exit_d = exit_ok;
        end else if (ab == 2'b11) begin
          gate_d = G_OUT2;
        end
      end
      default: gate_d = G_IDLE;
    endcase
  end

  // End of day wins over any pending fill/empty transition.
  always_comb begin
    rush_d       = rush_q;
    start_rush_d = 1'b0;
    end_rush_d   = 1'b0;
    no_rush_d    = 1'b0;
    case (rush_q)
      R_WAIT: begin
        if (day_over) begin
          rush_d    = R_NONE;
          no_rush_d = 1'b1;
        end else if (count == CAP) begin
          rush_d       = R_RUSH;
          start_rush_d = 1'b1;
        end
      end
      R_RUSH: begin
        if (day_over) begin
          rush_d    = R_NONE;
          no_rush_d = 1'b1;
        end else if (count == 4'd0) begin
          rush_d     = R_DONE;
          end_rush_d = 1'b1;
        end
      end
      default: rush_d = rush_q;
    endcase
  end

  assign enter      = enter_q;
  assign exit       = exit_q;
  assign hour_inc   = hour_inc_q;
  assign start_rush = start_rush_q;
  assign end_rush   = end_rush_q;
  assign no_rush    = no_rush_q;
  assign day_done   = day_done_q;

endmodule

// File: tb/tb_parking_control.sv
// tb/tb_parking_control.sv - directed self-checking bench for parking_control
module tb_parking_control;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sensor_a = 1'b0;
  logic       sensor_b = 1'b0;
  logic       hour_key = 1'b0;
  logic [3:0] count = 4'd0;
  logic [3:0] hour = 4'd0;
  logic       enter, exit, hour_inc, start_rush, end_rush, no_rush, day_done;

  int n_cmp = 0;
  int n_bad = 0;
  int c_enter, c_exit, c_hinc, c_start, c_end, c_none;
  int s_enter, s_exit, s_hinc, s_start;

  parking_control dut (
    .clock(clock), .reset(reset),
    .sensor_a(sensor_a), .sensor_b(sensor_b), .hour_key(hour_key),
    .count(count), .hour(hour),
    .enter(enter), .exit(exit), .hour_inc(hour_inc),
    .start_rush(start_rush), .end_rush(end_rush), .no_rush(no_rush),
    .day_done(day_done)
  );

  always #5 clock = ~clock;

  task automatic clr();
    c_enter = 0; c_exit = 0; c_hinc = 0; c_start = 0; c_end = 0; c_none = 0;
    s_enter = 0; s_exit = 0; s_hinc = 0; s_start = 0;
  endtask

  // Advance n cycles, tallying pulses and the step (1-based) at which each was last seen.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (enter)      begin c_enter++; s_enter = i + 1; end
      if (exit)       begin c_exit++;  s_exit  = i + 1; end
      if (hour_inc)   begin c_hinc++;  s_hinc  = i + 1; end
      if (start_rush) begin c_start++; s_start = i + 1; end
      if (end_rush)   c_end++;
      if (no_rush)    c_none++;
    end
  endtask

  task automatic gate(input logic [1:0] ab, input int n);
    {sensor_a, sensor_b} = ab;
    run(n);
  endtask

  task automatic do_reset();
    sensor_a = 1'b0; sensor_b = 1'b0; hour_key = 1'b0;
    reset = 1'b0;
    run(2);
    reset = 1'b1;
    clr();
  endtask

  task automatic test_reset();
    reset = 1'b0; hour = 4'd8; count = 4'd3;
    clr();
    run(3);
    n_cmp++;
    if ({enter, exit, hour_inc, start_rush, end_rush, no_rush, day_done} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {enter, exit, hour_inc, start_rush, end_rush, no_rush, day_done});
    end
    n_cmp++;
    if (c_enter + c_exit + c_hinc + c_start + c_end + c_none !== 0) begin
      n_bad++;
      $display("FAIL reset_no_pulses: got %0d want 0", c_enter + c_exit + c_hinc + c_start + c_end + c_none);
    end
    hour = 4'd0; count = 4'd0;
    reset = 1'b1;
  endtask

  task automatic test_full_entry();
    count = 4'd0; hour = 4'd0;
    do_reset();
    gate(2'b00, 4); gate(2'b10, 4); gate(2'b11, 4); gate(2'b01, 4); gate(2'b00, 6);
    n_cmp++;
    if (c_enter !== 1) begin n_bad++; $display("FAIL entry_count: got %0d want 1", c_enter); end
    n_cmp++;
    if (s_enter !== 3) begin n_bad++; $display("FAIL entry_latency: got step %0d want 3", s_enter); end
    n_cmp++;
    if (c_exit !== 0) begin n_bad++; $display("FAIL entry_no_exit: got %0d want 0", c_exit); end
  endtask

  task automatic test_exit_abort();
    count = 4'd1; hour = 4'd0;
    do_reset();
    gate(2'b00, 4); gate(2'b01, 4); gate(2'b11, 4); gate(2'b10, 4); gate(2'b00, 6);
    n_cmp++;
    if (c_exit !== 1) begin n_bad++; $display("FAIL exit_count: got %0d want 1", c_exit); end
    n_cmp++;
    if (s_exit !== 3) begin n_bad++; $display("FAIL exit_latency: got step %0d want 3", s_exit); end
    n_cmp++;
    if (c_enter !== 0) begin n_bad++; $display("FAIL exit_no_enter: got %0d want 0", c_enter); end
    clr();
    gate(2'b10, 4); gate(2'b00, 6);
    gate(2'b10, 4); gate(2'b11, 4); gate(2'b10, 4); gate(2'b00, 6);
    n_cmp++;
    if (c_enter + c_exit !== 0) begin
      n_bad++; $display("FAIL abort_no_pulse: got %0d want 0", c_enter + c_exit);
    end
  endtask

  task automatic test_rush();
    count = 4'd0; hour = 4'd2;
    do_reset();
    run(3);
    count = 4'd3;
    clr();
    run(4);
    n_cmp++;
    if (c_start !== 1) begin n_bad++; $display("FAIL rush_start_count: got %0d want 1", c_start); end
    n_cmp++;
    if (s_start !== 1) begin n_bad++; $display("FAIL rush_start_latency: got step %0d want 1", s_start); end
    hour = 4'd5; count = 4'd0;
    clr();
    run(4);
    n_cmp++;
    if (c_end !== 1 || c_start !== 0) begin
      n_bad++; $display("FAIL rush_end: got end=%0d start=%0d want end=1 start=0", c_end, c_start);
    end
    hour = 4'd8;
    clr();
    run(1);
    n_cmp++;
    if (day_done !== 1'b1) begin n_bad++; $display("FAIL day_done_latency: got %b want 1", day_done); end
    run(3);
    n_cmp++;
    if (c_none !== 0) begin n_bad++; $display("FAIL rush_done_no_none: got %0d want 0", c_none); end
  endtask

  task automatic test_no_rush();
    count = 4'd2; hour = 4'd0;
    do_reset();
    for (int h = 0; h <= 8; h++) begin hour = 4'(h); run(2); end
    n_cmp++;
    if (c_none !== 1 || c_start !== 0) begin
      n_bad++; $display("FAIL no_rush_plain: got none=%0d start=%0d want none=1 start=0", c_none, c_start);
    end
    count = 4'd0; hour = 4'd1;
    do_reset();
    count = 4'd3;
    run(3);
    count = 4'd2;
    for (int h = 2; h <= 8; h++) begin hour = 4'(h); run(2); end
    n_cmp++;
    if (c_start !== 1 || c_none !== 1 || c_end !== 0) begin
      n_bad++;
      $display("FAIL no_rush_after_start: got start=%0d none=%0d end=%0d want 1 1 0", c_start, c_none, c_end);
    end
  endtask

  task automatic test_hour_key();
    count = 4'd0; hour = 4'd3;
    do_reset();
    hour_key = 1'b1;
    run(20);
    n_cmp++;
    if (c_hinc !== 1) begin n_bad++; $display("FAIL hour_key_count: got %0d want 1", c_hinc); end
    n_cmp++;
    if (s_hinc !== 3) begin n_bad++; $display("FAIL hour_key_latency: got step %0d want 3", s_hinc); end
    hour_key = 1'b0;
    run(4);
    hour = 4'd8;
    clr();
    hour_key = 1'b1;
    run(6);
    hour_key = 1'b0;
    n_cmp++;
    if (c_hinc !== 0) begin n_bad++; $display("FAIL hour_key_day_over: got %0d want 0", c_hinc); end
  endtask

  task automatic test_back_to_back();
    count = 4'd0; hour = 4'd0;
    do_reset();
    gate(2'b00, 4); gate(2'b10, 4); gate(2'b11, 4); gate(2'b01, 4);
    hour_key = 1'b1;
    gate(2'b00, 6);
    hour_key = 1'b0;
    n_cmp++;
    if (c_enter !== 1 || c_hinc !== 1 || s_enter !== 3 || s_hinc !== 3) begin
      n_bad++;
      $display("FAIL coincident_pulses: got enter=%0d@%0d hinc=%0d@%0d want 1@3 1@3",
               c_enter, s_enter, c_hinc, s_hinc);
    end
  endtask

  task automatic test_guard();
    count = 4'd3; hour = 4'd0;
    do_reset();
    gate(2'b00, 4); gate(2'b10, 4); gate(2'b11, 4); gate(2'b01, 4); gate(2'b00, 6);
    count = 4'd0;
    gate(2'b01, 4); gate(2'b11, 4); gate(2'b10, 4); gate(2'b00, 6);
`ifdef PARKING_CONTROL_FULL_GUARD_EN
    n_cmp++;
    if (c_enter !== 0) begin n_bad++; $display("FAIL guard_enter_full: got %0d want 0", c_enter); end
    n_cmp++;
    if (c_exit !== 0) begin n_bad++; $display("FAIL guard_exit_empty: got %0d want 0", c_exit); end
`else
    n_cmp++;
    if (c_enter !== 1) begin n_bad++; $display("FAIL unguarded_enter_full: got %0d want 1", c_enter); end
    n_cmp++;
    if (c_exit !== 1) begin n_bad++; $display("FAIL unguarded_exit_empty: got %0d want 1", c_exit); end
`endif
  endtask

  task automatic test_mid_reset();
    count = 4'd0; hour = 4'd8;
    do_reset();
    gate(2'b00, 4); gate(2'b10, 4); gate(2'b11, 4);
    n_cmp++;
    if (day_done !== 1'b1) begin n_bad++; $display("FAIL mid_reset_pre_day_done: got %b want 1", day_done); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({enter, exit, hour_inc, start_rush, end_rush, no_rush, day_done} !== 7'b0) begin
      n_bad++;
      $display("FAIL mid_reset_immediate: got %b want 0000000",
               {enter, exit, hour_inc, start_rush, end_rush, no_rush, day_done});
    end
    run(2);
    reset = 1'b1;
    clr();
    gate(2'b00, 6);
    n_cmp++;
    if (c_enter + c_exit !== 0) begin
      n_bad++; $display("FAIL mid_reset_no_pulse: got %0d want 0", c_enter + c_exit);
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_full_entry();
    test_exit_abort();
    test_rush();
    test_no_rush();
    test_hour_key();
    test_back_to_back();
    test_guard();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
